// File: rtl/bitpacker_scheduler_if.sv
// Codeword request channels and the bitpacker write port of bitpacker_scheduler.
// The scheduler is the slave; whoever feeds codewords and consumes bp_* is the master.
interface bitpacker_scheduler_if #(
    parameter int NUM_REQ = 3
);
    // Handshake: channel i transfers on a rising clock edge when req_valid[i] && req_ready[i];
    // req_ready is combinational and at most one-hot, and bp_data_valid is a one-cycle strobe.
    logic [NUM_REQ-1:0]    req_valid;
    logic [32*NUM_REQ-1:0] req_data;
    logic [6*NUM_REQ-1:0]  req_length;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  bp_data_valid;
    logic [31:0]           bp_data;
    logic [5:0]            bp_length;

    modport master (
        output req_valid, req_data, req_length,
        input  req_ready, bp_data_valid, bp_data, bp_length
    );

    modport slave (
        input  req_valid, req_data, req_length,
        output req_ready, bp_data_valid, bp_data, bp_length
    );
endinterface

// File: rtl/bitpacker_scheduler.sv
// Round-robin scheduler that feeds Huffman codewords from several channels into one bitpacker,
// tracks the partial-word fill level, and pads to a 32-bit boundary on flush.
module bitpacker_scheduler #(
    parameter int NUM_REQ = 3,
    parameter int WCNT_W  = 16
) (
    input  logic                 clock,
    input  logic                 nreset,
    bitpacker_scheduler_if.slave bus,
    input  logic                 flush_request,
    output logic                 flush_done,
    output logic [4:0]           fill_level,
    output logic [WCNT_W-1:0]    word_count,
    output logic [1:0]           dbg_state
);
    localparam int PW = (NUM_REQ > 2) ? 2 : 1;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        PAD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [PW-1:0]     r_ptr;
    logic              r_bp_valid;
    logic [31:0]       r_bp_data;
    logic [5:0]        r_bp_length;
    logic              r_flush_done;
    logic [4:0]        r_fill;
    logic [WCNT_W-1:0] r_wcnt;

    logic              w_gnt_any;
    logic [PW-1:0]     w_gnt_idx;
    logic [NUM_REQ-1:0] w_ready;
    logic [31:0]       w_sel_data;
    logic [5:0]        w_sel_len;
    logic [5:0]        w_sum;
    logic [PW-1:0]     w_next_ptr;

    // r_ptr is the channel searched first; flush in RUN blocks every grant that cycle.
    always_comb begin : p_arb
        int c;
        c         = 0;
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        if (r_state == RUN && !flush_request) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                c = int'(r_ptr) + k;
                if (c >= NUM_REQ) c = c - NUM_REQ;
                if (!w_gnt_any && bus.req_valid[PW'(c)]) begin
                    w_gnt_any = 1'b1;
                    w_gnt_idx = PW'(c);
                end
            end
        end
    end

    always_comb begin
        w_ready    = w_gnt_any ? (NUM_REQ'(1) << w_gnt_idx) : '0;
        w_sel_data = bus.req_data[32*w_gnt_idx +: 32];
        w_sel_len  = bus.req_length[6*w_gnt_idx +: 6];
        w_sum      = 6'(r_fill) + w_sel_len;
        w_next_ptr = (w_gnt_idx == PW'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
    end

    // Legal lengths keep w_sum <= 63, so bit 5 is exactly "a full word was completed".
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_state      <= RUN;
            r_ptr        <= '0;
            r_bp_valid   <= 1'b0;
            r_bp_data    <= '0;
            r_bp_length  <= '0;
            r_flush_done <= 1'b0;
            r_fill       <= '0;
            r_wcnt       <= '0;
        end else begin
            r_bp_valid   <= 1'b0;
            r_flush_done <= 1'b0;
            case (r_state)
                RUN: begin
                    if (flush_request) begin
                        r_state <= PAD;
                    end else if (w_gnt_any) begin
                        r_ptr <= w_next_ptr;
                        if (w_sel_len != 6'd0) begin
                            r_bp_valid  <= 1'b1;
                            r_bp_data   <= w_sel_data;
                            r_bp_length <= w_sel_len;
                            r_fill      <= w_sum[4:0];
                            if (w_sum[5]) r_wcnt <= r_wcnt + 1'b1;
                        end
                    end
                end
                PAD: begin
                    if (r_fill != 5'd0) begin
                        r_bp_valid  <= 1'b1;
                        r_bp_data   <= 32'hFFFF_FFFF;
                        r_bp_length <= 6'd32 - 6'(r_fill);
                        r_fill      <= '0;
                        r_wcnt      <= r_wcnt + 1'b1;
                    end
                    r_state <= DONE;
                end
                DONE: begin
                    r_flush_done <= 1'b1;
                    r_state      <= RUN;
                end
                default: r_state <= RUN;
            endcase
        end
    end

    assign bus.req_ready     = w_ready;
    assign bus.bp_data_valid = r_bp_valid;
    assign bus.bp_data       = r_bp_data;
    assign bus.bp_length     = r_bp_length;
    assign flush_done        = r_flush_done;
    assign fill_level        = r_fill;
    assign word_count        = r_wcnt;
    assign dbg_state         = r_state;
endmodule
